// File: rtl/plotter_pkg.sv
// Shared types and constants for the point plotter.
// - plot_state_t      : write-port owner (IDLE = plot pipeline, CLEAR = sweep)
// - FB_DEFAULT_*      : default frame-buffer geometry
// - X_W / Y_W         : projected coordinate widths, matching the projection output
// - sat_inc()         : saturating increment for the 16-bit statistics counters
package plotter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } plot_state_t;

  localparam int FB_DEFAULT_WIDTH  = 320;
  localparam int FB_DEFAULT_HEIGHT = 180;
  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/point_plotter_fb_addr_gen.sv
// fb_addr_gen: first plot stage. Registers the point valid, the linear
// frame-buffer address y*FB_WIDTH+x and the off-screen flag (1-cycle latency).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_flush        drop whatever is being loaded this cycle (clear start)
//   i_vld, i_x, i_y  incoming point
//   o_vld, o_off, o_addr  registered point, off-screen flag, linear address
module fb_addr_gen
  import plotter_pkg::*;
#(
  parameter int FB_WIDTH  = FB_DEFAULT_WIDTH,
  parameter int FB_HEIGHT = FB_DEFAULT_HEIGHT,
  parameter int ADDR_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_vld,
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  output logic              o_vld,
  output logic              o_off,
  output logic [ADDR_W-1:0] o_addr
);

  logic              w_off;
  logic [ADDR_W-1:0] w_addr;

  assign w_off  = (int'(i_x) >= FB_WIDTH) || (int'(i_y) >= FB_HEIGHT);
  // Off-screen points may wrap here; the flag suppresses their write.
  assign w_addr = ADDR_W'(i_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(i_x);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_vld <= 1'b0;
    end else begin
      o_vld <= i_vld;
    end
    o_off  <= w_off;
    o_addr <= w_addr;
  end

endmodule

// File: rtl/point_plotter.sv
// point_plotter: rasterises projected (x, y) points as single lit pixels into
// the frame buffer write port, and owns the full-buffer clear sweep.
// Ports:
//   clk_camera, sys_rst        clock, synchronous active-high reset
//   point_valid/_x/_y          one-cycle point strobe, no backpressure
//   clear_req                  request a full clear (ignored while clearing)
//   fb_addr/fb_we/fb_din       frame buffer write port (registered)
//   busy                       high while the clear sweep owns the port
//   points_plotted/_dropped    saturating statistics
module point_plotter
  import plotter_pkg::*;
#(
  parameter int FB_WIDTH  = FB_DEFAULT_WIDTH,
  parameter int FB_HEIGHT = FB_DEFAULT_HEIGHT,
  parameter int PIX_BITS  = 1,
  parameter int ADDR_W    = 16
) (
  input  logic                clk_camera,
  input  logic                sys_rst,
  input  logic                point_valid,
  input  logic [X_W-1:0]      point_x,
  input  logic [Y_W-1:0]      point_y,
  input  logic                clear_req,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic                fb_we,
  output logic [PIX_BITS-1:0] fb_din,
  output logic                busy,
  output logic [CNT_W-1:0]    points_plotted,
  output logic [CNT_W-1:0]    points_dropped
);

  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  // One extra bit so the sweep can count to FB_PIXELS itself.
  localparam int SWP_W = ADDR_W + 1;

  plot_state_t         r_state;
  logic [SWP_W-1:0]    r_sweep;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic                r_fb_we;
  logic [PIX_BITS-1:0] r_fb_din;
  logic                r_busy;
  logic [CNT_W-1:0]    r_points_plotted;
  logic [CNT_W-1:0]    r_points_dropped;

  logic              w_idle;
  logic              w_clr_go;
  logic              w_s1_vld;
  logic              w_s1_off;
  logic [ADDR_W-1:0] w_s1_addr;
  logic              w_plot;
  logic              w_drop;

  assign w_idle   = (r_state == IDLE);
  assign w_clr_go = w_idle && clear_req;

  // Points only enter while idle; a starting clear flushes stage 1.
  fb_addr_gen #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .i_clk  (clk_camera),
    .i_rst  (sys_rst),
    .i_flush(w_clr_go),
    .i_vld  (point_valid && w_idle),
    .i_x    (point_x),
    .i_y    (point_y),
    .o_vld  (w_s1_vld),
    .o_off  (w_s1_off),
    .o_addr (w_s1_addr)
  );

  // A clear start also discards stage 2, so flushed points are not counted.
  assign w_plot = w_idle && !clear_req && w_s1_vld && !w_s1_off;
  // The two drop sources are mutually exclusive in any one cycle.
  assign w_drop = (w_idle && !clear_req && w_s1_vld && w_s1_off) ||
                  (point_valid && (!w_idle || clear_req));

  always_ff @(posedge clk_camera) begin
    if (sys_rst) begin
      r_state          <= CLEAR;
      r_busy           <= 1'b1;
      r_sweep          <= '0;
      r_fb_we          <= 1'b0;
      r_fb_addr        <= '0;
      r_fb_din         <= '0;
      r_points_plotted <= '0;
      r_points_dropped <= '0;
    end else begin
      r_fb_we          <= 1'b0;
      r_points_plotted <= sat_inc(r_points_plotted, w_plot);
      r_points_dropped <= sat_inc(r_points_dropped, w_drop);
      case (r_state)
        CLEAR: begin
          // Leave one cycle after the last address has been presented.
          if (r_sweep == SWP_W'(FB_PIXELS)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= r_sweep[ADDR_W-1:0];
            r_fb_din  <= '0;
            r_sweep   <= r_sweep + SWP_W'(1);
          end
        end
        IDLE: begin
          if (clear_req) begin
            // Address 0 goes out immediately, so the sweep continues from 1.
            r_state   <= CLEAR;
            r_busy    <= 1'b1;
            r_fb_we   <= 1'b1;
            r_fb_addr <= '0;
            r_fb_din  <= '0;
            r_sweep   <= SWP_W'(1);
          end else if (w_plot) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= w_s1_addr;
            r_fb_din  <= '1;
          end
        end
      endcase
    end
  end

  assign fb_addr        = r_fb_addr;
  assign fb_we          = r_fb_we;
  assign fb_din         = r_fb_din;
  assign busy           = r_busy;
  assign points_plotted = r_points_plotted;
  assign points_dropped = r_points_dropped;

endmodule

// File: tb/tb_point_plotter.sv
// Self-checking bench for point_plotter. The reference model schedules every
// expected frame-buffer write and counter step by cycle number from the
// behavioural rules, and all outputs are compared every cycle.
module tb_point_plotter;
  import plotter_pkg::*;

  localparam int W = 320;
  localparam int H = 180;
  localparam int N = W * H;

  logic        gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic        rst = 1'b1;
  logic        pv  = 1'b0;
  logic        clr = 1'b0;
  logic [8:0]  px  = '0;
  logic [7:0]  py  = '0;
  logic [15:0] addr;
  logic        we;
  logic [0:0]  din;
  logic        bsy;
  logic [15:0] npl;
  logic [15:0] ndr;

  point_plotter #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .PIX_BITS(1), .ADDR_W(16)
  ) dut (
    .clk_camera    (gclk),
    .sys_rst       (rst),
    .point_valid   (pv),
    .point_x       (px),
    .point_y       (py),
    .clear_req     (clr),
    .fb_addr       (addr),
    .fb_we         (we),
    .fb_din        (din),
    .busy          (bsy),
    .points_plotted(npl),
    .points_dropped(ndr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: clear window, scheduled plot writes and drop events by cycle.
  int known_from  = -1;
  int busy_from   = 0;
  int cs          = 0;
  int rst_zero_at = -1;
  int exp_plot[int];
  bit off_drop[int];
  bit arr_drop[int];
  int m_plot = 0;
  int m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit in_clear(input int k);
    return (k >= busy_from) && (k <= cs + N - 1);
  endfunction

  task automatic check_cycle();
    bit ewe;
    int ea;
    int ed;
    if (known_from < 0 || cyc < known_from) return;
    if (rst_zero_at == cyc) begin
      m_plot = 0;
      m_drop = 0;
    end
    if (exp_plot.exists(cyc) && m_plot < 'hFFFF) m_plot++;
    if ((off_drop.exists(cyc) || arr_drop.exists(cyc)) && m_drop < 'hFFFF) m_drop++;
    ewe = 1'b0; ea = 0; ed = 0;
    if (cyc >= cs && cyc <= cs + N - 1) begin
      ewe = 1'b1; ea = cyc - cs; ed = 0;
    end else if (exp_plot.exists(cyc)) begin
      ewe = 1'b1; ea = exp_plot[cyc]; ed = 1;
    end
    chk("fb_we", we, ewe);
    if (ewe) begin
      chk("fb_addr", addr, ea);
      chk("fb_din", din, ed);
    end
    chk("busy", bsy, in_clear(cyc));
    chk("plotted", npl, m_plot);
    chk("dropped", ndr, m_drop);
  endtask

  task automatic model(input bit v, input int x, input int y, input bit c, input bit r);
    int k;
    k = cyc;
    if (r) begin
      exp_plot.delete(); off_drop.delete(); arr_drop.delete();
      rst_zero_at = k + 1;
      busy_from   = k + 1;
      cs          = k + 2;
      if (known_from < 0) known_from = k + 1;
      return;
    end
    if (known_from < 0) return;
    if (in_clear(k)) begin
      if (v) arr_drop[k+1] = 1'b1;
      return;
    end
    if (c) begin
      // Anything that would surface next cycle is flushed uncounted.
      exp_plot.delete(k + 1);
      off_drop.delete(k + 1);
      busy_from = k + 1;
      cs        = k + 1;
      if (v) arr_drop[k+1] = 1'b1;
      return;
    end
    if (v) begin
      if (x >= W || y >= H) off_drop[k+2] = 1'b1;
      else                  exp_plot[k+2] = y * W + x;
    end
  endtask

  task automatic tick(input bit v, input int x, input int y, input bit c, input bit r);
    @(negedge gclk);
    check_cycle();
    pv = v; px = 9'(x); py = 8'(y); clr = c; rst = r;
    model(v, x, y, c, r);
    @(posedge gclk);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_x();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, W - 1));
  endfunction

  function automatic int rnd_y();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, H - 1));
  endfunction

  // Random points and clear requests while a sweep is known to be running.
  task automatic rnd_sweep_tick();
    tick($urandom_range(0, 15) == 0, rnd_x(), rnd_y(), $urandom_range(0, 31) == 0, 0);
  endtask

  task automatic force_sat();
    @(negedge gclk);
    check_cycle();
    pv = 0; clr = 0; rst = 0;
    model(0, 0, 0, 0, 0);
    force dut.r_points_plotted = 16'hFFFE;
    #1;
    release dut.r_points_plotted;
    m_plot = 'hFFFE;
    @(posedge gclk);
    cyc++;
  endtask

  initial begin
    // Reset, a short sweep, a mid-sweep reset, then one full sweep.
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    repeat (40) rnd_sweep_tick();
    tick(0, 0, 0, 0, 1);
    repeat (N) rnd_sweep_tick();
    idle(3);

    // Single point, latency and address.
    tick(1, 10, 2, 0, 0);
    idle(3);
    // Back-to-back corners.
    tick(1, 0, 0, 0, 0);
    tick(1, 319, 179, 0, 0);
    tick(1, 5, 1, 0, 0);
    idle(3);
    // Just off-screen on each axis.
    tick(1, 320, 0, 0, 0);
    tick(1, 0, 180, 0, 0);
    idle(3);
    // Random traffic in IDLE.
    repeat (300) tick($urandom_range(0, 1), rnd_x(), rnd_y(), 0, 0);
    idle(3);

    // Counter saturation.
    force_sat();
    tick(1, 1, 1, 0, 0);
    tick(1, 2, 1, 0, 0);
    tick(1, 3, 1, 0, 0);
    idle(4);

    // Points in flight when a clear starts, one arriving with clear_req.
    tick(1, 7, 7, 0, 0);
    tick(1, 8, 8, 1, 0);
    repeat (100) rnd_sweep_tick();
    tick(0, 0, 0, 1, 0);
    repeat (100) rnd_sweep_tick();
    // Reset mid-sweep restarts from address 0.
    tick(0, 0, 0, 0, 1);
    repeat (40) rnd_sweep_tick();
    @(negedge gclk);
    check_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
